ram_bus_arbiter: RTL and testbench
==================================

Name: ram_bus_arbiter

Overview:
- Shares the single-port 8-bit program/data RAM between two bus masters.
  - Master 0 is the CPU.
  - Master 1 is the program loader/debug port, which fills RAM before the CPU runs and inspects it afterwards.
- Accepts one request at a time per master over a req/ack handshake and drives the RAM address/data/write-enable bus.
- Honours the RAM's fixed read latency and returns read data with a one-cycle ack pulse.
- Sits between the masters and the RAM module; it replaces direct CPU-to-RAM wiring.

Parameters:
- AW, 8: address width.
- DW, 8: data width.
- RD_LAT, 2: cycles from ram_addr first driven to ram_rdata valid. Legal range is 1..15; 0 is illegal (elaboration error).
- PRIO_MODE, 0: 0 = round-robin; 1 = fixed priority, master 0 always wins.

Ports:
- clk_qzt  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  master 0 request; payload must be stable while high until ack.
- m0_we  in  1  master 0: 1 = write, 0 = read.
- m0_addr  in  AW  master 0 address.
- m0_wdata  in  DW  master 0 write data.
- m0_ack  out  1  master 0 one-cycle completion pulse.
- m0_rdata  out  DW  master 0 read data; valid from its ack cycle until the next master-0 read completes.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as master 0, for master 1.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  DW  RAM read data.
- busy  out  1  high in any state other than IDLE.
- owner  out  1  index of the current or most recent grant.

Behaviour:
- Reset values (asynchronous):
  - state = IDLE.
  - All outputs are 0: ram_addr, ram_wdata, ram_we, m0/m1_ack, m0/m1_rdata, busy, owner.
  - last_owner = 1, so master 0 wins the first tie.
- FSM is IDLE -> ADDR -> (read only: WAIT) -> ACK -> IDLE.
- IDLE:
  - If any req is high, select a winner, latch its addr, wdata and we, set owner, and go to ADDR.
  - If no req is high, stay in IDLE.
- Arbitration:
  - A single requester always wins.
  - On a tie in round-robin mode, grant the master that is not last_owner.
  - In PRIO_MODE=1, a tie goes to master 0.
  - last_owner updates on grant.
- ADDR (1 cycle):
  - ram_addr and ram_wdata are driven from the latched values.
  - ram_we = latched we, for exactly this one cycle.
  - Write: go to ACK.
  - Read: go to WAIT with counter = RD_LAT.
- WAIT (RD_LAT cycles):
  - ram_we = 0 and ram_addr is held.
  - On the clock edge ending the last WAIT cycle, capture ram_rdata into the owner's rdata register, then go to ACK.
- ACK (1 cycle): owner's ack = 1, then go to IDLE.
- Latency, measured from the cycle in which req is first seen high in IDLE (cycle 0):
  - Write: ram_we high in cycle 1, ack in cycle 2, next grant possible in cycle 3.
  - Read: ram_addr driven from cycle 1, ram_rdata sampled at the end of cycle RD_LAT+1, ack in cycle RD_LAT+2.
- ram_we is 0 in every state except a write's ADDR cycle. ram_addr and ram_wdata hold their last values while IDLE.
- A write never changes either rdata register. The non-owner's ack and rdata are never touched.
- req held high after ack is treated as a new transaction and is arbitrated in the following IDLE cycle. The other master's pending req therefore wins under round-robin.
- req dropped mid-transaction: the transaction still completes (the write is still performed) and ack still pulses.
- Payload changes after the grant are ignored, because the latched copies are used.
- Reset asserted mid-transaction:
  - Everything returns to reset values immediately and ram_we drops asynchronously.
  - The transaction is lost; no ack is issued and the requester must reissue after reset.
- Starvation is impossible in round-robin mode: each master waits at most one foreign transaction.

Decomposition:
- Shared package mock8080_pkg holds:
  - FSM state encoding: IDLE=0, ADDR=1, WAIT=2, ACK=3, in 2 bits.
  - Default AW/DW = 8.
  - Constant RD_LAT_DEFAULT = 2.
- One sub-module, rr_arb2: a 2-way arbiter with the last_owner register and PRIO_MODE, outputting a grant-valid flag and the grant index.

Test Plan:
1. Reset mid-transaction: assert reset during a master-0 read WAIT -> ram_we=0, busy=0 and m0_ack=0 immediately; after release, a new m0 read of 0x10 completes normally.
2. Master-0 write then read: write addr 0x20, data 0xA5 -> ram_we high only in cycle 1 with ram_addr=0x20 and ram_wdata=0xA5, m0_ack in cycle 2. Then read 0x20 -> m0_rdata=0xA5 with m0_ack in cycle 4 (RD_LAT=2).
3. Simultaneous requests after reset, both held high with master 1 writing 0x5A to 0x30 and master 0 reading 0x30 -> master 0 is granted first (reads the old value), then master 1; owner sequence is 0, 1, 0, 1 over four transactions.
4. PRIO_MODE=1, both requests held continuously -> master 0 granted every time; m1_ack never pulses until m0_req drops.
5. Master 1 drops req one cycle after its grant on a write of 0x77 to 0x40 -> the RAM write still occurs, m1_ack still pulses, and a later read of 0x40 returns 0x77.
6. RD_LAT=1 and RD_LAT=4 builds, read of a RAM model with the matching latency -> ack in cycle 3 and cycle 6 respectively, with correct data; m1_rdata is unchanged by a master-0 read.

Source files
------------

// File: rtl/mock8080_pkg.sv
// ---------------------------------------------------------------------------
// mock8080_pkg : shared constants for the RAM bus arbiter slice. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mock8080_pkg;

  localparam int AW_DEFAULT     = 8;
  localparam int DW_DEFAULT     = 8;
  localparam int RD_LAT_DEFAULT = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_ACK  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2 : two-way arbiter, round-robin or fixed priority. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arb2 #(
  parameter int PRIO_MODE = 0
) (
  input  logic       clk_qzt,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic       valid_o,
  output logic       idx_o
);

  logic last_owner_q;
  logic last_owner_d;

  always_comb begin
    valid_o = |req_i;
    if (req_i == 2'b11) begin
      idx_o = (PRIO_MODE != 0) ? 1'b0 : ~last_owner_q;
    end else begin
      idx_o = req_i[1];
    end
    last_owner_d = take_i ? idx_o : last_owner_q;
  end

  // Reset to 1 so master 0 wins the very first tie.
  always_ff @(posedge clk_qzt or posedge reset) begin
    if (reset) begin
      last_owner_q <= 1'b1;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ram_bus_arbiter : shares the single-port RAM between CPU and loader. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_bus_arbiter
  import mock8080_pkg::*;
#(
  parameter int AW        = AW_DEFAULT,
  parameter int DW        = DW_DEFAULT,
  parameter int RD_LAT    = RD_LAT_DEFAULT,
  parameter int PRIO_MODE = 0
) (
  input  logic          clk_qzt,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy,
  output logic          owner
);

  if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
    $error("ram_bus_arbiter: RD_LAT must be in 1..15");
  end

  localparam logic [3:0] LAT_LOAD = 4'(RD_LAT);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          owner_q, owner_d;
  logic          ram_we_q, ram_we_d;
  logic          m0_ack_q, m0_ack_d;
  logic          m1_ack_q, m1_ack_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;

  logic          gnt_valid;
  logic          gnt_idx;
  logic          take;

  rr_arb2 #(
    .PRIO_MODE (PRIO_MODE)
  ) u_arb (
    .clk_qzt (clk_qzt),
    .reset   (reset),
    .req_i   ({m1_req, m0_req}),
    .take_i  (take),
    .valid_o (gnt_valid),
    .idx_o   (gnt_idx)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    owner_d    = owner_q;
    ram_we_d   = 1'b0;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    take       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          take     = 1'b1;
          owner_d  = gnt_idx;
          addr_d   = gnt_idx ? m1_addr  : m0_addr;
          wdata_d  = gnt_idx ? m1_wdata : m0_wdata;
          we_d     = gnt_idx ? m1_we    : m0_we;
          // Registered strobe so ram_we is high for exactly the ADDR cycle.
          ram_we_d = gnt_idx ? m1_we    : m0_we;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (we_q) begin
          m0_ack_d = ~owner_q;
          m1_ack_d = owner_q;
          state_d  = ST_ACK;
        end else begin
          cnt_d   = LAT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd1) begin
          if (owner_q) begin
            m1_rdata_d = ram_rdata;
          end else begin
            m0_rdata_d = ram_rdata;
          end
          m0_ack_d = ~owner_q;
          m1_ack_d = owner_q;
          state_d  = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_qzt or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      owner_q    <= 1'b0;
      ram_we_q   <= 1'b0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      owner_q    <= owner_d;
      ram_we_q   <= ram_we_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_we    = ram_we_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign owner     = owner_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_bus_arbiter : scoreboard bench over three arbiter builds. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ram_bus_arbiter;

  // Instance 0: round-robin, RD_LAT=2. Instance 1: fixed priority, RD_LAT=4.
  // Instance 2: round-robin, RD_LAT=1.
  logic       clk;
  logic       rst      [3];
  logic       m0_req   [3];
  logic       m0_we    [3];
  logic [7:0] m0_addr  [3];
  logic [7:0] m0_wdata [3];
  logic       m0_ack   [3];
  logic [7:0] m0_rdata [3];
  logic       m1_req   [3];
  logic       m1_we    [3];
  logic [7:0] m1_addr  [3];
  logic [7:0] m1_wdata [3];
  logic       m1_ack   [3];
  logic [7:0] m1_rdata [3];
  logic [7:0] ram_addr [3];
  logic [7:0] ram_wdata[3];
  logic       ram_we   [3];
  logic [7:0] ram_rdata[3];
  logic       busy     [3];
  logic       owner    [3];

  typedef struct {
    int         m;
    bit         we;
    logic [7:0] data;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] shadow [3][256];
  int         n_vec = 0;
  int         n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 4 : 1);
    localparam int PM  = (g == 1) ? 1 : 0;
    logic [7:0] mem  [256];
    logic [7:0] pipe [LAT];

    ram_bus_arbiter #(
      .AW(8), .DW(8), .RD_LAT(LAT), .PRIO_MODE(PM)
    ) u_dut (
      .clk_qzt  (clk),
      .reset    (rst[g]),
      .m0_req   (m0_req[g]),
      .m0_we    (m0_we[g]),
      .m0_addr  (m0_addr[g]),
      .m0_wdata (m0_wdata[g]),
      .m0_ack   (m0_ack[g]),
      .m0_rdata (m0_rdata[g]),
      .m1_req   (m1_req[g]),
      .m1_we    (m1_we[g]),
      .m1_addr  (m1_addr[g]),
      .m1_wdata (m1_wdata[g]),
      .m1_ack   (m1_ack[g]),
      .m1_rdata (m1_rdata[g]),
      .ram_addr (ram_addr[g]),
      .ram_wdata(ram_wdata[g]),
      .ram_we   (ram_we[g]),
      .ram_rdata(ram_rdata[g]),
      .busy     (busy[g]),
      .owner    (owner[g])
    );

    // RAM model: data for an address is valid LAT cycles after it is driven.
    always @(posedge clk) begin
      if (ram_we[g]) mem[ram_addr[g]] <= ram_wdata[g];
      pipe[0] <= mem[ram_addr[g]];
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign ram_rdata[g] = pipe[LAT-1];
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 4 : 1);
  endfunction

  function automatic logic [7:0] rdata_of(input int d, input int m);
    return (m != 0) ? m1_rdata[d] : m0_rdata[d];
  endfunction

  function automatic logic ack_of(input int d, input int m);
    return (m != 0) ? m1_ack[d] : m0_ack[d];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input int m, input bit r, input bit we,
                       input logic [7:0] a, input logic [7:0] wd);
    if (m == 0) begin
      m0_req[d] = r; m0_we[d] = we; m0_addr[d] = a; m0_wdata[d] = wd;
    end else begin
      m1_req[d] = r; m1_we[d] = we; m1_addr[d] = a; m1_wdata[d] = wd;
    end
  endtask

  task automatic wait_ack(input int d, output int who, output int cyc);
    who = -1;
    cyc = 0;
    while (who < 0 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (m0_ack[d]) who = 0;
      else if (m1_ack[d]) who = 1;
    end
  endtask

  // Single-master transaction; drop1 releases req and scrambles the payload
  // right after the grant.
  task automatic run_txn(input int d, input int m, input bit we, input logic [7:0] a,
                         input logic [7:0] wd, input bit drop1);
    exp_t       e;
    int         cyc;
    int         nwe;
    bit         got;
    logic [7:0] other_rd;
    other_rd = rdata_of(d, 1 - m);
    e.m    = m;
    e.we   = we;
    e.lat  = we ? 2 : lat_of(d) + 2;
    e.data = we ? 8'h00 : shadow[d][a];
    if (we) shadow[d][a] = wd;
    sb.push_back(e);
    drive(d, m, 1'b1, we, a, wd);
    cyc = 0; nwe = 0; got = 0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (drop1 && cyc == 1) drive(d, m, 1'b0, ~we, ~a, ~wd);
      if (cyc == 1) chk("ram_addr_c1", ram_addr[d], a);
      if (ram_we[d]) begin
        nwe++;
        chk("ram_we_cycle", cyc, 1);
        chk("ram_wdata", ram_wdata[d], wd);
      end
      if (ack_of(d, 1 - m)) chk("foreign_ack", 1, 0);
      if (ack_of(d, m)) got = 1;
    end
    drive(d, m, 1'b0, 1'b0, 8'h00, 8'h00);
    e = sb.pop_front();
    chk("ack_seen", 32'(got), 1);
    if (got) begin
      chk("ack_cycle", cyc, e.lat);
      chk("owner", 32'(owner[d]), e.m);
      if (!e.we) chk("rdata", rdata_of(d, m), e.data);
    end
    chk("ram_we_count", nwe, we ? 1 : 0);
    chk("other_rdata", rdata_of(d, 1 - m), other_rd);
    @(posedge clk); #1;
    chk("ack_pulse_end", 32'(ack_of(d, m)), 0);
    chk("idle_busy", 32'(busy[d]), 0);
  endtask

  task automatic pulse_reset(input int d);
    rst[d] = 1'b1;
    @(posedge clk); #1;
    rst[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    int   who;
    int   cyc;
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1;
      drive(d, 0, 1'b0, 1'b0, 8'h00, 8'h00);
      drive(d, 1, 1'b0, 1'b0, 8'h00, 8'h00);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_busy",     32'(busy[d]), 0);
      chk("rst_owner",    32'(owner[d]), 0);
      chk("rst_ram_we",   32'(ram_we[d]), 0);
      chk("rst_ram_addr", ram_addr[d], 0);
      chk("rst_ram_wd",   ram_wdata[d], 0);
      chk("rst_acks",     {m1_ack[d], m0_ack[d]}, 0);
      chk("rst_rdata",    {m1_rdata[d], m0_rdata[d]}, 0);
      rst[d] = 1'b0;
    end
    @(posedge clk); #1;

    // Reset during a master-0 read WAIT, then the read is reissued.
    run_txn(0, 1, 1'b1, 8'h10, 8'h3C, 1'b0);
    drive(0, 0, 1'b1, 1'b0, 8'h10, 8'h00);
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_busy", 32'(busy[0]), 1);
    rst[0] = 1'b1;
    #1;
    chk("mid_rst_we",    32'(ram_we[0]), 0);
    chk("mid_rst_busy",  32'(busy[0]), 0);
    chk("mid_rst_ack",   32'(m0_ack[0]), 0);
    chk("mid_rst_owner", 32'(owner[0]), 0);
    drive(0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    @(posedge clk); #1;
    run_txn(0, 0, 1'b0, 8'h10, 8'h00, 1'b0);

    // Master-0 write then read back.
    run_txn(0, 0, 1'b1, 8'h20, 8'hA5, 1'b0);
    run_txn(0, 0, 1'b0, 8'h20, 8'h00, 1'b0);

    // Master 1 drops req right after its grant; the write still lands.
    run_txn(0, 1, 1'b1, 8'h40, 8'h77, 1'b1);
    run_txn(0, 0, 1'b0, 8'h40, 8'h00, 1'b0);

    // Simultaneous held requests after reset, round-robin.
    run_txn(0, 1, 1'b1, 8'h30, 8'h11, 1'b0);
    pulse_reset(0);
    chk("rst_m0_rdata", m0_rdata[0], 0);
    sb.push_back('{m: 0, we: 1'b0, data: 8'h11, lat: 0});
    sb.push_back('{m: 1, we: 1'b1, data: 8'h00, lat: 0});
    sb.push_back('{m: 0, we: 1'b0, data: 8'h5A, lat: 0});
    sb.push_back('{m: 1, we: 1'b1, data: 8'h00, lat: 0});
    drive(0, 0, 1'b1, 1'b0, 8'h30, 8'h00);
    drive(0, 1, 1'b1, 1'b1, 8'h30, 8'h5A);
    for (int k = 0; k < 4; k++) begin
      wait_ack(0, who, cyc);
      e = sb.pop_front();
      if (k == 3) begin
        drive(0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(0, 1, 1'b0, 1'b0, 8'h00, 8'h00);
      end
      chk("rr_who", who, e.m);
      chk("rr_owner", 32'(owner[0]), e.m);
      if (!e.we) chk("rr_rdata", m0_rdata[0], e.data);
    end
    shadow[0][8'h30] = 8'h5A;
    @(posedge clk); #1;
    chk("rr_idle", 32'(busy[0]), 0);
    run_txn(0, 0, 1'b0, 8'h30, 8'h00, 1'b0);

    // Fixed priority: master 0 wins every tie until it drops req.
    run_txn(1, 1, 1'b1, 8'h50, 8'hC3, 1'b0);
    for (int k = 0; k < 3; k++) sb.push_back('{m: 0, we: 1'b0, data: 8'hC3, lat: 0});
    sb.push_back('{m: 1, we: 1'b1, data: 8'h00, lat: 0});
    drive(1, 0, 1'b1, 1'b0, 8'h50, 8'h00);
    drive(1, 1, 1'b1, 1'b1, 8'h50, 8'h99);
    for (int k = 0; k < 4; k++) begin
      wait_ack(1, who, cyc);
      e = sb.pop_front();
      if (k == 2) drive(1, 0, 1'b0, 1'b0, 8'h00, 8'h00);
      if (k == 3) drive(1, 1, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("prio_who", who, e.m);
      if (!e.we) chk("prio_rdata", m0_rdata[1], e.data);
    end
    shadow[1][8'h50] = 8'h99;
    @(posedge clk); #1;

    // Latency builds: RD_LAT=4 (instance 1) and RD_LAT=1 (instance 2).
    run_txn(1, 1, 1'b0, 8'h50, 8'h00, 1'b0);
    run_txn(1, 0, 1'b0, 8'h50, 8'h00, 1'b0);
    run_txn(2, 1, 1'b1, 8'h60, 8'hE1, 1'b0);
    run_txn(2, 1, 1'b0, 8'h60, 8'h00, 1'b0);
    run_txn(2, 0, 1'b1, 8'h61, 8'h2D, 1'b0);
    run_txn(2, 0, 1'b0, 8'h61, 8'h00, 1'b0);
    chk("lat1_m1_rdata", m1_rdata[2], 8'hE1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
